uart_tick_gen: RTL and testbench

Parametrised UART timing source that replaces the separate baud divider and TX tick stage. It produces an oversampled receive tick, a once-per-bit transmit tick and a mid-bit sampling strobe. The divisor has a fractional extension, and the oversampling ratio is selectable. It sits between the UART register file (divisor/mode fields) and the TX/RX shift-register FSMs. Configuration is captured only while the block is disabled, so ticks never glitch mid-frame.

---
 rtl/uart_tick_gen.sv | 102 ++++++++++
 tb/tb_uart_tick_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tick_gen.sv
// UART timing source: fractional baud divider producing oversampled rx ticks,
// per-bit tx ticks and a mid-bit sampling strobe.
module uart_tick_gen #(
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned FRAC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  divisor,
    input  logic [FRAC_W-1:0] frac,
    input  logic [1:0]        osr_sel,
    output logic              rx_tick,
    output logic              tx_tick,
    output logic              mid_tick,
    output logic [4:0]        os_phase
);

    localparam int unsigned CNT_W = DIV_W + 1;
    localparam int unsigned PH_W  = 5;

    logic [DIV_W-1:0]  d_s;
    logic [FRAC_W-1:0] f_s;
    logic [PH_W-1:0]   osr_s;
    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic              ext;

    logic [PH_W-1:0]   osr_in;
    logic [CNT_W-1:0]  len;
    logic [CNT_W-1:0]  cnt_inc;
    logic              tick_nxt;
    logic [PH_W-1:0]   osr_last;
    logic [PH_W-1:0]   osr_mid;
    logic [PH_W-1:0]   ph_nxt;
    logic [FRAC_W:0]   acc_sum;

    // Oversampling ratio decode
    always_comb begin
        osr_in = PH_W'(16);
        case (osr_sel)
            2'b00:   osr_in = PH_W'(16);
            2'b01:   osr_in = PH_W'(13);
            2'b10:   osr_in = PH_W'(8);
            default: osr_in = PH_W'(4);
        endcase
    end

    // Period length, expiry detect and next oversample phase
    always_comb begin
        len      = CNT_W'(d_s) + CNT_W'(ext);
        cnt_inc  = cnt + CNT_W'(1);
        tick_nxt = (cnt_inc == len);
        osr_last = osr_s - PH_W'(1);
        osr_mid  = (osr_s >> 1) - PH_W'(1);
        acc_sum  = {1'b0, acc} + {1'b0, f_s};
        ph_nxt   = os_phase;
        if (rx_tick) begin
            ph_nxt = (os_phase == osr_last) ? '0 : os_phase + PH_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_s      <= '0;
            f_s      <= '0;
            osr_s    <= PH_W'(16);
            cnt      <= '0;
            acc      <= '0;
            ext      <= 1'b0;
            os_phase <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            mid_tick <= 1'b0;
        end else if (!en || d_s == '0) begin
            // Disabled (or zero divisor): clear counters; shadows track inputs only when disabled
            if (!en) begin
                d_s   <= divisor;
                f_s   <= frac;
                osr_s <= osr_in;
            end
            cnt      <= '0;
            acc      <= '0;
            ext      <= 1'b0;
            os_phase <= '0;
            rx_tick  <= 1'b0;
            tx_tick  <= 1'b0;
            mid_tick <= 1'b0;
        end else begin
            cnt      <= tick_nxt ? '0 : cnt_inc;
            rx_tick  <= tick_nxt;
            os_phase <= ph_nxt;
            tx_tick  <= tick_nxt && (ph_nxt == osr_last);
            mid_tick <= tick_nxt && (ph_nxt == osr_mid);
            if (tick_nxt) begin
                acc <= acc_sum[FRAC_W-1:0];
                ext <= acc_sum[FRAC_W];
            end
        end
    end

endmodule

// File: tb/tb_uart_tick_gen.sv
// Bench for uart_tick_gen: fixed vector table, test-plan sequences and
// randomized runs against an arithmetic tick-schedule model.
module tb_uart_tick_gen;

    localparam int unsigned DIV_W  = 16;
    localparam int unsigned FRAC_W = 4;

    logic              clk = 1'b0;
    logic              rst, en;
    logic [DIV_W-1:0]  divisor;
    logic [FRAC_W-1:0] frac;
    logic [1:0]        osr_sel;
    logic              rx_tick, tx_tick, mid_tick;
    logic [4:0]        os_phase;

    uart_tick_gen #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst), .en(en), .divisor(divisor), .frac(frac),
        .osr_sel(osr_sel), .rx_tick(rx_tick), .tx_tick(tx_tick),
        .mid_tick(mid_tick), .os_phase(os_phase)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int rst, en, div, frac, osr;
        int rx, tx, mid, ph;
    } vec_t;

    // Model: shadows plus a schedule of tick edges counted in enabled edges
    int m_ds, m_fs, m_osr;
    int m_n, m_next, m_k;
    int e_rx, e_tx, e_mid, e_ph;
    int tick_q[$];
    int first_tx, first_mid_ph;

    function automatic int osr_of(input int s);
        case (s)
            0: return 16;
            1: return 13;
            2: return 8;
            default: return 4;
        endcase
    endfunction

    task automatic check(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_n = 0; m_k = 0; m_next = m_ds;
        e_rx = 0; e_tx = 0; e_mid = 0; e_ph = 0;
    endtask

    task automatic model_edge();
        int carry;
        if (rst) begin
            m_ds = 0; m_fs = 0; m_osr = 16;
            model_clear();
        end else if (!en) begin
            m_ds = int'(divisor); m_fs = int'(frac); m_osr = osr_of(int'(osr_sel));
            model_clear();
        end else if (m_ds == 0) begin
            model_clear();
        end else begin
            m_n++;
            e_rx = (m_n == m_next) ? 1 : 0;
            if (e_rx == 1) begin
                m_k++;
                carry = ((m_k * m_fs) >> FRAC_W) - (((m_k - 1) * m_fs) >> FRAC_W);
                m_next = m_n + m_ds + carry;
            end
            e_ph  = (e_rx == 1) ? (m_k - 1) % m_osr : m_k % m_osr;
            e_tx  = (e_rx == 1 && e_ph == m_osr - 1) ? 1 : 0;
            e_mid = (e_rx == 1 && e_ph == m_osr / 2 - 1) ? 1 : 0;
        end
    endtask

    // One clock edge: advance the model, then sample the DUT 1 time unit later
    task automatic do_edge();
        model_edge();
        @(posedge clk);
        #1;
        if (rx_tick) tick_q.push_back(m_n);
        if (tx_tick && first_tx < 0) first_tx = m_n;
        if (mid_tick && first_mid_ph < 0) first_mid_ph = int'(os_phase);
    endtask

    task automatic step();
        do_edge();
        check("rx_tick", int'(rx_tick), e_rx);
        check("tx_tick", int'(tx_tick), e_tx);
        check("mid_tick", int'(mid_tick), e_mid);
        check("os_phase", int'(os_phase), e_ph);
    endtask

    task automatic configure(input int d, input int f, input int o);
        rst = 0; en = 0;
        divisor = DIV_W'(d); frac = FRAC_W'(f); osr_sel = 2'(o);
        step();
        tick_q.delete(); first_tx = -1; first_mid_ph = -1;
        en = 1;
    endtask

    vec_t tbl[16];

    initial begin
        rst = 1; en = 0; divisor = '0; frac = '0; osr_sel = '0;
        first_tx = -1; first_mid_ph = -1;
        m_ds = 0; m_fs = 0; m_osr = 16;
        model_clear();

        // rst en div frac osr | rx tx mid ph
        tbl[0]  = '{1, 0, 0, 0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 0, 1, 0, 3,  0, 0, 0, 0};
        tbl[2]  = '{0, 1, 1, 0, 3,  1, 0, 0, 0};
        tbl[3]  = '{0, 1, 1, 0, 3,  1, 0, 1, 1};
        tbl[4]  = '{0, 1, 1, 0, 3,  1, 0, 0, 2};
        tbl[5]  = '{0, 1, 1, 0, 3,  1, 1, 0, 3};
        tbl[6]  = '{0, 1, 1, 0, 3,  1, 0, 0, 0};
        tbl[7]  = '{0, 0, 1, 0, 3,  0, 0, 0, 0};
        tbl[8]  = '{0, 1, 7, 0, 0,  1, 0, 0, 0};
        tbl[9]  = '{1, 1, 7, 0, 0,  0, 0, 0, 0};
        tbl[10] = '{0, 1, 3, 0, 0,  0, 0, 0, 0};
        tbl[11] = '{0, 0, 2, 0, 3,  0, 0, 0, 0};
        tbl[12] = '{0, 1, 2, 0, 3,  0, 0, 0, 0};
        tbl[13] = '{0, 1, 2, 0, 3,  1, 0, 0, 0};
        tbl[14] = '{0, 1, 2, 0, 3,  0, 0, 0, 1};
        tbl[15] = '{0, 1, 2, 0, 3,  1, 0, 1, 1};

        for (int i = 0; i < 16; i++) begin
            rst = 1'(tbl[i].rst); en = 1'(tbl[i].en);
            divisor = DIV_W'(tbl[i].div); frac = FRAC_W'(tbl[i].frac);
            osr_sel = 2'(tbl[i].osr);
            do_edge();
            check($sformatf("tbl%0d_rx", i), int'(rx_tick), tbl[i].rx);
            check($sformatf("tbl%0d_tx", i), int'(tx_tick), tbl[i].tx);
            check($sformatf("tbl%0d_mid", i), int'(mid_tick), tbl[i].mid);
            check($sformatf("tbl%0d_ph", i), int'(os_phase), tbl[i].ph);
        end

        // D=5, OSR=16: first rx at edge 5, first tx at edge 80, mid at phase 7
        configure(5, 0, 0);
        repeat (200) step();
        check("d5_first_rx", (tick_q.size() > 0) ? tick_q[0] : -1, 5);
        check("d5_first_tx", first_tx, 80);
        check("d5_mid_phase", first_mid_ph, 7);

        // Fractional F=8: 32 periods after the first tick total 176 cycles
        configure(5, 8, 0);
        for (int c = 0; c < 400 && tick_q.size() < 33; c++) step();
        check("frac8_span", (tick_q.size() >= 33) ? tick_q[32] - tick_q[0] : -1, 176);

        // Fractional F=1: one long period per 16
        configure(5, 1, 0);
        for (int c = 0; c < 400 && tick_q.size() < 17; c++) step();
        check("frac1_span", (tick_q.size() >= 17) ? tick_q[16] - tick_q[0] : -1, 81);

        // Config changes while enabled are ignored until en drops
        configure(5, 0, 0);
        repeat (12) step();
        divisor = DIV_W'(3); osr_sel = 2'(1);
        tick_q.delete();
        repeat (30) step();
        check("frozen_period", (tick_q.size() >= 2) ? tick_q[1] - tick_q[0] : -1, 5);
        en = 0;
        step();
        en = 1; tick_q.delete(); first_tx = -1; first_mid_ph = -1;
        repeat (100) step();
        check("reload_period", (tick_q.size() >= 2) ? tick_q[1] - tick_q[0] : -1, 3);
        check("reload_first_tx", first_tx, 39);
        check("reload_mid_phase", first_mid_ph, 5);

        // Zero divisor: never ticks
        configure(0, 0, 0);
        repeat (200) step();
        check("d0_ticks", tick_q.size(), 0);

        // Reset mid-bit at os_phase 9, then stays idle
        configure(2, 0, 0);
        for (int c = 0; c < 100 && !(os_phase == 5'd9 && !rx_tick); c++) step();
        check("reached_ph9", int'(os_phase), 9);
        rst = 1;
        step();
        check("rst_rx", int'(rx_tick), 0);
        check("rst_tx", int'(tx_tick), 0);
        check("rst_ph", int'(os_phase), 0);
        rst = 0; divisor = DIV_W'(4); tick_q.delete();
        repeat (50) step();
        check("post_rst_idle", tick_q.size(), 0);

        // Randomized segments with in-flight config changes, en drops and resets
        for (int s = 0; s < 25; s++) begin
            int len;
            configure(($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 9)),
                      int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
            len = int'($urandom_range(40, 300));
            for (int c = 0; c < len; c++) begin
                if ($urandom_range(0, 19) == 0) begin
                    divisor = DIV_W'($urandom_range(0, 9));
                    frac    = FRAC_W'($urandom_range(0, 15));
                    osr_sel = 2'($urandom_range(0, 3));
                end
                en  = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
                rst = ($urandom_range(0, 249) == 0) ? 1'b1 : 1'b0;
                step();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
